// File: rtl/dcache_ctrl_64_if.sv
// Bundle of CPU, tag RAM, data RAM and memory-bus signals around the data cache controller.
// master = controller side, slave = CPU / RAMs / memory side.
interface dcache_ctrl_64_if #(
  parameter int unsigned PABITS = 36
);
  localparam int unsigned TW = PABITS - 10;

  logic              Cpu_Read;
  logic              Cpu_Write;
  logic [PABITS-3:0] Cpu_PAddr;
  logic              Cpu_Ack;
  logic              Busy;
  logic [5:0]        Tag_Index;
  logic [TW-1:0]     Tag_Cmp;
  logic [TW-1:0]     Tag_Set;
  logic              Tag_Write;
  logic              Tag_Valid;
  logic              Tag_Dirty;
  logic [TW-1:0]     Match_Tag;
  logic              Match_Hit;
  logic              Match_Valid;
  logic              Match_Dirty;
  logic [7:0]        Data_Index;
  logic              Data_Write;
  logic              Data_Sel;
  logic              Mem_Read;
  logic              Mem_Write;
  logic [PABITS-3:0] Mem_Addr;
  logic              Mem_Ready;

  modport master (
    input  Cpu_Read, Cpu_Write, Cpu_PAddr, Match_Tag, Match_Hit, Match_Valid, Match_Dirty,
           Mem_Ready,
    output Cpu_Ack, Busy, Tag_Index, Tag_Cmp, Tag_Set, Tag_Write, Tag_Valid, Tag_Dirty,
           Data_Index, Data_Write, Data_Sel, Mem_Read, Mem_Write, Mem_Addr
  );

  modport slave (
    output Cpu_Read, Cpu_Write, Cpu_PAddr, Match_Tag, Match_Hit, Match_Valid, Match_Dirty,
           Mem_Ready,
    input  Cpu_Ack, Busy, Tag_Index, Tag_Cmp, Tag_Set, Tag_Write, Tag_Valid, Tag_Dirty,
           Data_Index, Data_Write, Data_Sel, Mem_Read, Mem_Write, Mem_Addr
  );
endinterface

// File: rtl/dcache_ctrl_64.sv
// Sequencing controller for the 64-set, 16-byte-line data cache: lookup, hit completion,
// dirty-victim writeback and line fill, then a reissued lookup that completes as a hit.
module dcache_ctrl_64 #(
  parameter int unsigned PABITS = 36
) (
  input logic              clock,
  input logic              reset,
  dcache_ctrl_64_if.master bus
);
  localparam int unsigned TW = PABITS - 10;

  typedef enum logic [2:0] {
    StIdle, StLookup, StWbRd, StWbWr, StFill, StUpdate, StReissue
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [PABITS-3:0] addr_q, addr_d;
  logic              wr_q, wr_d;
  logic [TW-1:0]     victim_q, victim_d;

  logic [5:0]    set_q;
  logic [1:0]    word_q;
  logic [TW-1:0] tag_q;

  assign set_q  = addr_q[7:2];
  assign word_q = addr_q[1:0];
  assign tag_q  = addr_q[PABITS-3:8];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 2'd0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wr_d     = wr_q;
    victim_d = victim_q;
    unique case (state_q)
      StIdle: begin
        if (bus.Cpu_Read || bus.Cpu_Write) begin
          addr_d  = bus.Cpu_PAddr;
          wr_d    = bus.Cpu_Write;  // simultaneous read+write is treated as a write
          state_d = StLookup;
        end
      end
      StLookup: begin
        if (bus.Match_Hit) begin
          state_d = StIdle;
        end else begin
          cnt_d = 2'd0;
          if (bus.Match_Valid && bus.Match_Dirty) begin
            victim_d = bus.Match_Tag;
            state_d  = StWbRd;
          end else begin
            state_d = StFill;
          end
        end
      end
      StWbRd: state_d = StWbWr;
      StWbWr: begin
        if (bus.Mem_Ready) begin
          cnt_d   = cnt_q + 2'd1;
          state_d = (cnt_q == 2'd3) ? StFill : StWbRd;
        end
      end
      StFill: begin
        if (bus.Mem_Ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = StUpdate;
        end
      end
      StUpdate:  state_d = StReissue;
      StReissue: state_d = StLookup;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.Cpu_Ack    = 1'b0;
    bus.Busy       = (state_q != StIdle);
    bus.Tag_Index  = set_q;
    bus.Tag_Cmp    = tag_q;
    bus.Tag_Set    = tag_q;
    bus.Tag_Write  = 1'b0;
    bus.Tag_Valid  = 1'b0;
    bus.Tag_Dirty  = 1'b0;
    bus.Data_Index = {set_q, word_q};
    bus.Data_Write = 1'b0;
    bus.Data_Sel   = 1'b0;
    bus.Mem_Read   = 1'b0;
    bus.Mem_Write  = 1'b0;
    bus.Mem_Addr   = {tag_q, set_q, cnt_q};
    unique case (state_q)
      StIdle: begin
        // Lookup starts in the accept cycle so results are back in the next one.
        bus.Tag_Index  = bus.Cpu_PAddr[7:2];
        bus.Data_Index = bus.Cpu_PAddr[7:0];
      end
      StLookup: begin
        if (bus.Match_Hit) begin
          bus.Cpu_Ack = 1'b1;
          if (wr_q) begin
            bus.Data_Write = 1'b1;
            bus.Tag_Write  = 1'b1;
            bus.Tag_Valid  = 1'b1;
            bus.Tag_Dirty  = 1'b1;
          end
        end
      end
      StWbRd: bus.Data_Index = {set_q, cnt_q};
      StWbWr: begin
        bus.Data_Index = {set_q, cnt_q};
        bus.Mem_Write  = 1'b1;
        bus.Mem_Addr   = {victim_q, set_q, cnt_q};
      end
      StFill: begin
        bus.Data_Index = {set_q, cnt_q};
        bus.Mem_Read   = 1'b1;
        bus.Data_Write = bus.Mem_Ready;
        bus.Data_Sel   = 1'b1;
      end
      StUpdate: begin
        bus.Tag_Write = 1'b1;
        bus.Tag_Valid = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_dcache_ctrl_64.sv
// Directed bench for dcache_ctrl_64: behavioural tag RAM, scripted memory ready timing,
// per-scenario tasks with inline checks.
module tb_dcache_ctrl_64;
  localparam int unsigned PABITS = 36;
  localparam int unsigned LIMIT  = 60;

  logic clock;
  logic reset;
  int   errors;
  int   checks;

  dcache_ctrl_64_if #(.PABITS(PABITS)) bus ();

  dcache_ctrl_64 #(.PABITS(PABITS)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Tag RAM model: {valid, dirty, tag}, one-cycle registered read.
  logic [27:0] tag_ram [64];
  logic [27:0] rd_q;
  always @(posedge clock) begin
    if (bus.Tag_Write) tag_ram[bus.Tag_Index] <= {bus.Tag_Valid, bus.Tag_Dirty, bus.Tag_Set};
    rd_q <= tag_ram[bus.Tag_Index];
  end
  assign bus.Match_Valid = rd_q[27];
  assign bus.Match_Dirty = rd_q[26];
  assign bus.Match_Tag   = rd_q[25:0];
  assign bus.Match_Hit   = rd_q[27] && (rd_q[25:0] == bus.Tag_Cmp);

  logic [33:0] rd_log[$];
  logic [33:0] wr_log[$];
  logic [8:0]  dw_log[$];
  logic [27:0] tw_log[$];
  int          viol;

  task automatic preset(input int set, input logic v, input logic d, input logic [25:0] tag);
    tag_ram[set] = {v, d, tag};
  endtask

  // Issues one request and runs it to Cpu_Ack, logging transfers and RAM writes.
  task automatic issue(input logic [33:0] addr, input logic rd, input logic wr,
                       input int delay, output int ack_cyc);
    int          waitc;
    logic        prev_pend, prev_rd, prev_wr;
    logic [33:0] prev_addr;
    rd_log.delete(); wr_log.delete(); dw_log.delete(); tw_log.delete();
    viol = 0; waitc = 0; prev_pend = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0; prev_addr = '0;
    ack_cyc = -1;
    @(negedge clock);
    bus.Cpu_PAddr = addr;
    bus.Cpu_Read  = rd;
    bus.Cpu_Write = wr;
    bus.Mem_Ready = (delay == 0);
    for (int c = 1; c <= LIMIT; c++) begin
      @(negedge clock);
      if (delay == 0) bus.Mem_Ready = 1'b1;
      else if (bus.Mem_Read || bus.Mem_Write) begin
        if (waitc == delay) begin
          bus.Mem_Ready = 1'b1;
          waitc = 0;
        end else begin
          bus.Mem_Ready = 1'b0;
          waitc++;
        end
      end else bus.Mem_Ready = 1'b0;
      #1;
      if (bus.Mem_Read && bus.Mem_Write) viol++;
      if (prev_pend && (bus.Mem_Read !== prev_rd || bus.Mem_Write !== prev_wr ||
                        bus.Mem_Addr !== prev_addr)) viol++;
      if (bus.Mem_Read && bus.Mem_Ready) rd_log.push_back(bus.Mem_Addr);
      if (bus.Mem_Write && bus.Mem_Ready) wr_log.push_back(bus.Mem_Addr);
      if (bus.Data_Write) dw_log.push_back({bus.Data_Sel, bus.Data_Index});
      if (bus.Tag_Write) tw_log.push_back({bus.Tag_Valid, bus.Tag_Dirty, bus.Tag_Set});
      prev_pend = (bus.Mem_Read || bus.Mem_Write) && !bus.Mem_Ready;
      prev_rd   = bus.Mem_Read;
      prev_wr   = bus.Mem_Write;
      prev_addr = bus.Mem_Addr;
      if (bus.Cpu_Ack) begin
        ack_cyc = c;
        break;
      end
    end
    bus.Cpu_Read  = 1'b0;
    bus.Cpu_Write = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.Cpu_Read = 1'b0; bus.Cpu_Write = 1'b0; bus.Cpu_PAddr = '0; bus.Mem_Ready = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
    checks++; if (bus.Cpu_Ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", bus.Cpu_Ack); end
    checks++; if ({bus.Mem_Read, bus.Mem_Write} !== 2'b00) begin errors++; $display("FAIL reset_mem got %b want 00", {bus.Mem_Read, bus.Mem_Write}); end
    checks++; if ({bus.Tag_Write, bus.Data_Write} !== 2'b00) begin errors++; $display("FAIL reset_wr got %b want 00", {bus.Tag_Write, bus.Data_Write}); end
    @(negedge clock);
    reset = 1'b0;
    bus.Cpu_PAddr = 34'h1234B;
    #1;
    checks++; if (bus.Tag_Index !== 6'h12) begin errors++; $display("FAIL idle_tag_index got %h want 12", bus.Tag_Index); end
    checks++; if (bus.Data_Index !== 8'h4B) begin errors++; $display("FAIL idle_data_index got %h want 4b", bus.Data_Index); end
  endtask

  task automatic test_read_hit();
    int ack;
    preset(6'h10, 1'b1, 1'b0, 26'h7);
    issue(34'h742, 1'b1, 1'b0, 0, ack);
    checks++; if (ack !== 1) begin errors++; $display("FAIL rhit_ack got %0d want 1", ack); end
    checks++; if (rd_log.size() + wr_log.size() !== 0) begin errors++; $display("FAIL rhit_mem got %0d want 0", rd_log.size() + wr_log.size()); end
    checks++; if (tw_log.size() + dw_log.size() !== 0) begin errors++; $display("FAIL rhit_writes got %0d want 0", tw_log.size() + dw_log.size()); end
  endtask

  task automatic test_write_hit(input logic both);
    int ack;
    if (!both) preset(6'h23, 1'b1, 1'b0, 26'h0);
    issue(34'h8D, both, 1'b1, 0, ack);
    checks++; if (ack !== 1) begin errors++; $display("FAIL whit_ack got %0d want 1", ack); end
    checks++; if (tw_log.size() !== 1 || tw_log[0] !== {2'b11, 26'h0}) begin errors++; $display("FAIL whit_tag got n=%0d %h want 1 %h", tw_log.size(), tw_log[0], {2'b11, 26'h0}); end
    checks++; if (dw_log.size() !== 1 || dw_log[0] !== 9'h08D) begin errors++; $display("FAIL whit_data got n=%0d %h want 1 08d", dw_log.size(), dw_log[0]); end
  endtask

  task automatic test_clean_miss();
    int ack;
    preset(6'h05, 1'b0, 1'b0, 26'h0);
    issue(34'h914, 1'b1, 1'b0, 0, ack);
    checks++; if (ack !== 8) begin errors++; $display("FAIL clean_ack got %0d want 8", ack); end
    checks++; if (wr_log.size() !== 0 || rd_log.size() !== 4) begin errors++; $display("FAIL clean_xfers got wr=%0d rd=%0d want 0 4", wr_log.size(), rd_log.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd_log[i] !== 34'h914 + 34'(i)) begin errors++; $display("FAIL clean_addr%0d got %h want %h", i, rd_log[i], 34'h914 + 34'(i)); end
      checks++; if (dw_log[i] !== 9'h114 + 9'(i)) begin errors++; $display("FAIL clean_fill%0d got %h want %h", i, dw_log[i], 9'h114 + 9'(i)); end
    end
    checks++; if (tw_log.size() !== 1 || tw_log[0] !== {2'b10, 26'h9}) begin errors++; $display("FAIL clean_update got n=%0d %h", tw_log.size(), tw_log[0]); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL clean_proto got %0d want 0", viol); end
  endtask

  task automatic test_dirty_miss();
    int ack;
    preset(6'h03, 1'b1, 1'b1, 26'h5);
    issue(34'hA0D, 1'b0, 1'b1, 0, ack);
    checks++; if (ack !== 16) begin errors++; $display("FAIL dirty_ack got %0d want 16", ack); end
    checks++; if (wr_log.size() !== 4 || rd_log.size() !== 4) begin errors++; $display("FAIL dirty_xfers got wr=%0d rd=%0d want 4 4", wr_log.size(), rd_log.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr_log[i] !== 34'h50C + 34'(i)) begin errors++; $display("FAIL dirty_wb%0d got %h want %h", i, wr_log[i], 34'h50C + 34'(i)); end
      checks++; if (rd_log[i] !== 34'hA0C + 34'(i)) begin errors++; $display("FAIL dirty_fill%0d got %h want %h", i, rd_log[i], 34'hA0C + 34'(i)); end
    end
    checks++; if (dw_log.size() !== 5 || dw_log[4] !== 9'h00D) begin errors++; $display("FAIL dirty_store got n=%0d %h want 5 00d", dw_log.size(), dw_log[4]); end
    checks++; if (tw_log.size() !== 2 || tw_log[0] !== {2'b10, 26'hA} || tw_log[1] !== {2'b11, 26'hA}) begin errors++; $display("FAIL dirty_tags got n=%0d %h %h", tw_log.size(), tw_log[0], tw_log[1]); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL dirty_proto got %0d want 0", viol); end
  endtask

  task automatic test_mem_wait();
    int ack;
    preset(6'h06, 1'b0, 1'b0, 26'h0);
    issue(34'h218, 1'b1, 1'b0, 3, ack);
    checks++; if (ack !== 20) begin errors++; $display("FAIL wait_ack got %0d want 20", ack); end
    checks++; if (rd_log.size() !== 4 || rd_log[3] !== 34'h21B) begin errors++; $display("FAIL wait_fill got n=%0d %h want 4 21b", rd_log.size(), rd_log[3]); end
    checks++; if (dw_log.size() !== 4) begin errors++; $display("FAIL wait_dw got %0d want 4", dw_log.size()); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL wait_stable got %0d want 0", viol); end
  endtask

  task automatic test_reset_mid();
    int   ack;
    logic found;
    preset(6'h08, 1'b1, 1'b1, 26'h5);
    found = 1'b0;
    @(negedge clock);
    bus.Cpu_PAddr = 34'h120; bus.Cpu_Read = 1'b1; bus.Mem_Ready = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      #1;
      if (bus.Mem_Write && bus.Mem_Addr == 34'h521) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL midrst_reach got %b want 1", found); end
    #1 reset = 1'b1;
    #1;
    checks++; if ({bus.Mem_Write, bus.Mem_Read} !== 2'b00) begin errors++; $display("FAIL midrst_mem got %b want 00", {bus.Mem_Write, bus.Mem_Read}); end
    checks++; if ({bus.Busy, bus.Cpu_Ack, bus.Tag_Write, bus.Data_Write} !== 4'b0000) begin errors++; $display("FAIL midrst_outs got %b want 0000", {bus.Busy, bus.Cpu_Ack, bus.Tag_Write, bus.Data_Write}); end
    bus.Cpu_Read = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    issue(34'h120, 1'b1, 1'b0, 0, ack);
    checks++; if (wr_log.size() !== 4 || wr_log[0] !== 34'h520) begin errors++; $display("FAIL midrst_restart got n=%0d %h want 4 520", wr_log.size(), wr_log[0]); end
    checks++; if (ack !== 16) begin errors++; $display("FAIL midrst_ack got %0d want 16", ack); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 64; i++) tag_ram[i] = '0;
    test_reset();
    test_read_hit();
    test_write_hit(1'b0);
    test_clean_miss();
    test_dirty_miss();
    test_mem_wait();
    test_write_hit(1'b1);
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl_64.md
Name: dcache_ctrl_64

Overview:
- Sequencing controller for the 64-set data cache.
- Sits between the CPU load/store port, the tag/flag RAM (64 sets, one-cycle read latency), the line data RAM and the memory bus.
- Drives tag lookups, consumes the hit/valid/dirty results, then performs one of: hit completion, dirty-victim writeback plus line fill, or clean fill.
- Cache geometry: 16-byte lines (4 words). Tag = PA[PABITS-1:10], index = PA[9:4], word = PA[3:2].

Parameters:
- PABITS, 36, physical address width in bits; tag width is PABITS-10.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- Cpu_Read  in  1  load request; held until Cpu_Ack
- Cpu_Write  in  1  store request; held until Cpu_Ack
- Cpu_PAddr  in  PABITS-2  word address [PABITS-1:2]; stable while request held
- Cpu_Ack  out  1  one-cycle completion pulse
- Busy  out  1  high in every state except IDLE
- Tag_Index  out  6  set index to tag RAM
- Tag_Cmp  out  PABITS-10  latched request tag
- Tag_Set  out  PABITS-10  tag value to write
- Tag_Write  out  1  tag RAM write enable
- Tag_Valid  out  1  valid bit to write
- Tag_Dirty  out  1  dirty bit to write
- Match_Tag  in  PABITS-10  stored tag (one cycle after Tag_Index)
- Match_Hit  in  1  hit result
- Match_Valid  in  1  stored valid bit
- Match_Dirty  in  1  stored dirty bit
- Data_Index  out  8  {set, word} address to data RAM (one-cycle read latency)
- Data_Write  out  1  data RAM write enable
- Data_Sel  out  1  data RAM write source: 0 = CPU store data, 1 = memory read data
- Mem_Read  out  1  word read request; held until Mem_Ready
- Mem_Write  out  1  word write request; held until Mem_Ready
- Mem_Addr  out  PABITS-2  word address for the memory transfer
- Mem_Ready  in  1  completes the current word transfer; may arrive in the same cycle as the request

Behaviour:

Reset:
- Asynchronous; state returns to IDLE and the counter clears.
- All registered outputs go to 0: Cpu_Ack, Tag_Write, Data_Write, Mem_Read, Mem_Write.
- Any in-flight memory word is abandoned; the memory side is reset by the same signal.

Lookup addressing:
- In IDLE, Tag_Index and Data_Index[7:2] are driven combinationally from Cpu_PAddr[9:4]; Data_Index[1:0] = Cpu_PAddr[3:2].
- In all other states both indexes come from the latched address.

States:
- IDLE: on Cpu_Read|Cpu_Write, latch address and op, then go to LOOKUP. If both are asserted, treat the request as a write.
- LOOKUP, on Match_Hit:
  - Read: pulse Cpu_Ack, go to IDLE.
  - Write: pulse Cpu_Ack, assert Data_Write with Data_Sel=0, and assert Tag_Write with Valid=1, Dirty=1, Tag_Set = latched tag; go to IDLE.
- LOOKUP, on miss:
  - Match_Valid & Match_Dirty: latch Match_Tag as the victim tag, clear the counter, go to WB_RD.
  - Otherwise: clear the counter, go to FILL.
- WB_RD: Data_Index = {set, cnt}; go to WB_WR.
- WB_WR: Mem_Write=1, Mem_Addr = {victim, set, cnt}, Data_Index held. On Mem_Ready, cnt+1; if cnt was 3, clear cnt and go to FILL, else go to WB_RD.
- FILL: Mem_Read=1, Mem_Addr = {tag, set, cnt}. On Mem_Ready: Data_Write=1, Data_Sel=1, Data_Index = {set, cnt}, cnt+1. After word 3, go to UPDATE.
- UPDATE: Tag_Write=1, Valid=1, Dirty=0, Tag_Set = tag; go to REISSUE.
- REISSUE: drive Tag_Index/Data_Index again; go to LOOKUP, which now hits and completes as a normal hit.

Rules:
- The counter is 2 bits and wraps from 3 to 0 at each phase end.
- Mem_Ready outside WB_WR or FILL is ignored.
- Cpu_Ack is never asserted outside LOOKUP.
- Mem_Read and Mem_Write are never asserted together.
- Minimum latency from the request-accept cycle:
  - Hit: Ack at +1.
  - Clean miss: Ack at +8.
  - Dirty miss: Ack at +16.
  - Each Mem_Ready wait cycle adds one cycle.

Test Plan:
- Reset, then a read at an address whose tag RAM entry is preset valid and matching (Match_Hit=1) -> Cpu_Ack exactly 1 cycle after accept; no Mem_*; no Tag_Write.
- Write hit at PA 0x0_0000_0234 -> Ack at +1; Tag_Write=1, Dirty=1, Valid=1, Tag_Set=0x0; Data_Write=1, Data_Sel=0, Data_Index=0x8D.
- Clean miss (Match_Valid=0), Mem_Ready always 1 -> Mem_Addr steps through word offsets 0,1,2,3 of the line; 4 Data_Write pulses with Data_Sel=1; UPDATE writes Dirty=0; Ack at +8.
- Dirty miss with victim tag 0x5 at set 3 -> 4 Mem_Write transfers at {0x5,3,0..3}, then 4 fills at the new tag; Ack at +16.
- Mem_Ready delayed 3 cycles per word on a clean miss -> requests held stable; Ack at +20.
- Reset asserted during WB_WR -> outputs 0 immediately; Busy=0; next request restarts from IDLE with the counter at 0.
